// File: rtl/age_arb_pkg.sv
// Shared types and reset helpers for the oldest-first age-matrix arbiter.
// Optional feature macro: AGE_ARB_GRANT_REG_EN (registered grant output).
package age_arb_pkg;

    localparam int AGE_ARB_WIDTH = 4;
    // Upper bound on WIDTH supported by the reset-row helper.
    localparam int AGE_ARB_MAX_W = 64;

    typedef logic [AGE_ARB_WIDTH-1:0] row_t;
    typedef logic [AGE_ARB_MAX_W-1:0] row_max_t;

    // Reset row i: entry i is older than every higher-numbered entry.
    function automatic row_max_t init_row(int i);
        row_max_t r;
        for (int j = 0; j < AGE_ARB_MAX_W; j++) r[j] = (j > i);
        return r;
    endfunction

endpackage

// File: rtl/age_arb_pick.sv
// Combinational oldest-valid selection from the relative-age matrix.
module age_arb_pick
    import age_arb_pkg::*;
#(
    parameter int WIDTH = AGE_ARB_WIDTH
) (
    input  logic [WIDTH-1:0] v_vld,
    input  logic [WIDTH-1:0] vv_matrix [WIDTH],
    output logic [WIDTH-1:0] v_grant
);

    // A requester wins when every other valid requester is younger than it.
    always_comb begin
        v_grant = '0;
        for (int i = 0; i < WIDTH; i++) begin
            v_grant[i] = v_vld[i];
            for (int j = 0; j < WIDTH; j++) begin
                if (j != i) v_grant[i] = v_grant[i] & (~v_vld[j] | vv_matrix[i][j]);
            end
        end
    end

endmodule

// File: rtl/age_matrix_arbiter.sv
// Age-matrix arbiter: relative-age state, youngest-on-alloc update and oldest-first grant.
// Define AGE_ARB_GRANT_REG_EN to present the grant one cycle later from a register.
module age_matrix_arbiter
    import age_arb_pkg::*;
#(
    parameter int WIDTH = AGE_ARB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] v_vld,
    input  logic             alloc_en,
    input  logic [WIDTH-1:0] v_alloc,
    output logic [WIDTH-1:0] v_grant,
    output logic [WIDTH-1:0] vv_matrix [WIDTH]
);

    logic [WIDTH-1:0] m [WIDTH];
    logic [WIDTH-1:0] grant_c;

    // Row i in the alloc set loses seniority over non-members (AND with set);
    // otherwise it gains seniority over members (OR with set). Diagonal stays 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) m[i] <= WIDTH'(init_row(i));
        end else if (alloc_en) begin
            for (int i = 0; i < WIDTH; i++)
                m[i] <= v_alloc[i] ? (m[i] & v_alloc) : (m[i] | v_alloc);
        end
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++) vv_matrix[i] = m[i];
    end

    age_arb_pick #(.WIDTH(WIDTH)) u_pick (
        .v_vld     (v_vld),
        .vv_matrix (m),
        .v_grant   (grant_c)
    );

`ifdef AGE_ARB_GRANT_REG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) v_grant <= '0;
        else        v_grant <= grant_c;
    end
`else
    assign v_grant = grant_c;
`endif

endmodule

// File: tb/tb_age_matrix_arbiter.sv
// Self-checking bench: randomized and directed stimulus against an age-ordered list model.
module tb_age_matrix_arbiter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] v_vld = '0;
    logic         man_en = 1'b0;
    logic [W-1:0] man_alloc = '0;
    bit           tie = 1'b0;
    logic         alloc_en;
    logic [W-1:0] v_alloc;
    logic [W-1:0] v_grant;
    logic [W-1:0] vv_matrix [W];

    int errors = 0;
    int checks = 0;
    int order[$];   // requester indices, oldest first

    assign alloc_en = tie ? |v_grant : man_en;
    assign v_alloc  = tie ? v_grant : man_alloc;

    age_matrix_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .v_vld     (v_vld),
        .alloc_en  (alloc_en),
        .v_alloc   (v_alloc),
        .v_grant   (v_grant),
        .vv_matrix (vv_matrix)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        order = {};
        for (int i = 0; i < W; i++) order.push_back(i);
    endfunction

    function automatic logic [W-1:0] model_grant(logic [W-1:0] vld);
        foreach (order[k]) if (vld[order[k]]) return W'(1) << order[k];
        return '0;
    endfunction

    function automatic void model_alloc(logic [W-1:0] a);
        int keep[$];
        int young[$];
        foreach (order[k]) begin
            if (a[order[k]]) young.push_back(order[k]);
            else             keep.push_back(order[k]);
        end
        order = {keep, young};
    endfunction

    function automatic int pos(int x);
        foreach (order[k]) if (order[k] == x) return k;
        return -1;
    endfunction

    function automatic logic [W-1:0] model_row(int i);
        logic [W-1:0] r = '0;
        for (int j = 0; j < W; j++) if (j != i) r[j] = pos(i) < pos(j);
        return r;
    endfunction

    // Advance one clock; the model consumes the alloc set the bench is presenting.
    task automatic tick();
        logic [W-1:0] a;
        a = tie ? model_grant(v_vld) : (man_en ? man_alloc : '0);
        @(posedge clk);
        model_alloc(a);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        for (int i = 0; i < W; i++) begin
            checks++;
            if (vv_matrix[i] !== model_row(i)) begin
                errors++;
                $display("FAIL reset_row%0d got=%b want=%b", i, vv_matrix[i], model_row(i));
            end
        end
        v_vld = '0; #1;
        checks++;
        if (v_grant !== 4'b0000) begin
            errors++; $display("FAIL reset_idle_grant got=%b want=0000", v_grant);
        end
        v_vld = 4'b1111; #1;
        checks++;
        if (v_grant !== model_grant(v_vld)) begin
            errors++; $display("FAIL reset_grant got=%b want=%b", v_grant, model_grant(v_vld));
        end
    endtask

    task automatic test_rotation();
        tie = 1'b1;
        v_vld = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (v_grant !== model_grant(v_vld)) begin
                errors++; $display("FAIL rotation_c%0d got=%b want=%b", c, v_grant, model_grant(v_vld));
            end
            tick();
        end
    endtask

    task automatic test_idle();
        tie = 1'b1;
        v_vld = '0; #1;
        checks++;
        if (v_grant !== 4'b0000) begin
            errors++; $display("FAIL idle_grant got=%b want=0000", v_grant);
        end
        tick();
        for (int i = 0; i < W; i++) begin
            checks++;
            if (vv_matrix[i] !== model_row(i)) begin
                errors++; $display("FAIL idle_row%0d got=%b want=%b", i, vv_matrix[i], model_row(i));
            end
        end
    endtask

    task automatic test_manual_alloc();
        logic [W-1:0] vlds [3] = '{4'b1111, 4'b0101, 4'b1100};
        tie = 1'b0;
        rst_n = 1'b0; #1; rst_n = 1'b1;
        model_reset();
        man_en = 1'b1; man_alloc = 4'b0101;
        tick();
        man_en = 1'b0; man_alloc = '0;
        for (int i = 0; i < W; i++) begin
            checks++;
            if (vv_matrix[i] !== model_row(i)) begin
                errors++; $display("FAIL manual_row%0d got=%b want=%b", i, vv_matrix[i], model_row(i));
            end
        end
        foreach (vlds[k]) begin
            v_vld = vlds[k]; #1;
            checks++;
            if (v_grant !== model_grant(v_vld)) begin
                errors++; $display("FAIL manual_grant vld=%b got=%b want=%b", v_vld, v_grant, model_grant(v_vld));
            end
        end
    endtask

    task automatic test_alloc_disabled();
        tie = 1'b0;
        man_en = 1'b0; man_alloc = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            v_vld = W'($urandom);
            tick();
            for (int i = 0; i < W; i++) begin
                checks++;
                if (vv_matrix[i] !== model_row(i)) begin
                    errors++; $display("FAIL disabled_row%0d got=%b want=%b", i, vv_matrix[i], model_row(i));
                end
                for (int j = 0; j < W; j++) begin
                    if (i != j && vv_matrix[i][j] === vv_matrix[j][i]) begin
                        errors++; $display("FAIL antisym m[%0d][%0d] got=%b want=%b", i, j, vv_matrix[i][j], ~vv_matrix[j][i]);
                    end
                end
            end
        end
        man_alloc = '0;
    endtask

    task automatic test_async_reset();
        tie = 1'b1;
        v_vld = 4'b1111;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < W; i++) begin
            checks++;
            if (vv_matrix[i] !== model_row(i)) begin
                errors++; $display("FAIL async_rst_row%0d got=%b want=%b", i, vv_matrix[i], model_row(i));
            end
        end
        checks++;
        if (v_grant !== 4'b0001) begin
            errors++; $display("FAIL async_rst_grant got=%b want=0001", v_grant);
        end
        #1;
        rst_n = 1'b1;
        tick();
        checks++;
        if (v_grant !== model_grant(v_vld)) begin
            errors++; $display("FAIL post_rst_grant got=%b want=%b", v_grant, model_grant(v_vld));
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            v_vld     = W'($urandom);
            tie       = ($urandom_range(0, 1) == 1);
            man_en    = 1'($urandom);
            man_alloc = W'($urandom);
            #1;
            checks++;
            if (v_grant !== model_grant(v_vld)) begin
                errors++; $display("FAIL rand_grant c=%0d vld=%b got=%b want=%b", c, v_vld, v_grant, model_grant(v_vld));
            end
            tick();
            for (int i = 0; i < W; i++) begin
                checks++;
                if (vv_matrix[i] !== model_row(i)) begin
                    errors++; $display("FAIL rand_row%0d c=%0d got=%b want=%b", i, c, vv_matrix[i], model_row(i));
                end
            end
        end
        tie = 1'b0; man_en = 1'b0; man_alloc = '0;
    endtask

    initial begin
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_rotation();
        test_idle();
        test_manual_alloc();
        test_alloc_disabled();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
